// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx among NUM_REQ byte sources
// Optional busy-rise watchdog: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [DATA_W-1:0]          tx_data,
    output logic                       tx_send,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       arb_busy,
    output logic                       timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;
    logic [IDX_W-1:0]    grant_id_q, grant_id_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_send_q, tx_send_d;

    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic [IDX_W-1:0]    cand;
    logic [DATA_W-1:0]   sel_data;
    logic                accept;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                timeout_err_q, timeout_err_d;
`endif

    // Rotating-priority search starting just after the last served requester
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Byte of the current winner, selected with constant slice bases
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // A grant needs an idle arbiter and a quiet serializer (it may still be finishing after reset)
    assign accept = !reset && (state_q == IDLE) && win_found && !tx_busy;

    // One-hot ready toward the winner only while a transfer can happen this cycle
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    // Next-state and registered-output logic for the capture/send/wait sequence
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        tx_data_d    = tx_data_q;
        tx_send_d    = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    tx_data_d    = sel_data;
                    grant_id_d   = win_idx;
                    last_grant_d = win_idx;
                    tx_send_d    = 1'b1;
                    state_d      = SEND;
                end
            end
            SEND: begin
                state_d = WAIT_HI;
`ifdef UART_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Serializer never started: drop the byte, keep the rotation moving
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset also abandons any frame in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            grant_id_q   <= '0;
            tx_data_q    <= '0;
            tx_send_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            tx_data_q    <= tx_data_d;
            tx_send_q    <= tx_send_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Watchdog counter and its expiry pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign tx_data  = tx_data_q;
    assign tx_send  = tx_send_q;
    assign grant_id = grant_id_q;
    assign arb_busy = (state_q != IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single uart_tx serializer between NUM_REQ byte requesters with round-robin arbitration.
- Captures one byte from the winning requester, issues a one-cycle send pulse to uart_tx, then holds off until the frame has finished (busy rises, then falls).
- Sits between on-chip byte sources (debug, status, console) and uart_tx in top.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, byte width passed to uart_tx
- TIMEOUT_CYCLES, 1024, watchdog limit for busy to rise; used only with UART_ARB_TIMEOUT_EN

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester byte available
- req_data  in  NUM_REQ*DATA_W  requester i byte at bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot accept; byte i transfers on the edge where req_valid[i] && req_ready[i]
- tx_data  out  DATA_W  byte to uart_tx, registered
- tx_send  out  1  one-cycle send pulse to uart_tx, registered
- tx_busy  in  1  uart_tx frame in progress
- grant_id  out  $clog2(NUM_REQ)  index of the requester currently being served, registered
- arb_busy  out  1  high whenever state != IDLE
- timeout_err  out  1  one-cycle pulse on watchdog expiry (0 when the feature is compiled out)

Behaviour:
- Reset (async, immediate): state=IDLE, last_grant=NUM_REQ-1 (so req 0 wins first), tx_data=0, tx_send=0, grant_id=0, timeout_err=0, watchdog count=0. req_ready=0 while reset is high.
- Reset mid-frame aborts the sequence. The byte is not retried. The requester is not re-notified.
- FSM states: IDLE, SEND, WAIT_HI, WAIT_LO.
- IDLE:
  - Winner = first i with req_valid[i], searching last_grant+1, +2, ... modulo NUM_REQ.
  - req_ready is combinational: one-hot on the winner when state==IDLE and at least one req_valid is set. Otherwise all zero.
  - On the transfer edge: tx_data<=req_data[winner], grant_id<=winner, last_grant<=winner, state->SEND.
- SEND: tx_send=1 for exactly this cycle; state->WAIT_HI.
- WAIT_HI: stay until tx_busy==1, then ->WAIT_LO.
- WAIT_LO: stay until tx_busy==0, then ->IDLE. The next grant can occur in the first IDLE cycle.
- Latency: transfer edge to tx_send high is 1 cycle. Minimum transfer-to-transfer spacing is 4 cycles plus the frame time.
- tx_data and grant_id hold their values from capture until the next capture and are never changed mid-frame.
- Requesters must hold req_valid and req_data stable until accepted. Dropping req_valid before acceptance is legal; that requester is simply skipped.
- Single requester: is re-granted every frame. All valid: grant order rotates 0,1,2,3,0,...
- req_valid=0 everywhere: stays in IDLE with tx_send=0.
- tx_busy already high in IDLE (e.g. uart_tx still finishing after a reset): no grant is issued until tx_busy is low.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_HI and increments each WAIT_HI cycle.
  - If it reaches TIMEOUT_CYCLES with tx_busy still 0, the FSM goes to IDLE and timeout_err pulses for 1 cycle.
  - The byte is dropped; last_grant is still advanced.
- Undefined: WAIT_HI waits indefinitely, no counter is built, and timeout_err is tied to 0.

Test Plan:
- Reset check: assert reset mid-WAIT_LO with req_valid=4'b1111 -> all outputs 0 and state IDLE while reset is high. After release, the first grant goes to req 0.
- Single byte: req_valid=4'b0100, req_data[2]=8'hA5; busy model high 2 cycles after send for 10 cycles -> req_ready=4'b0100 for 1 cycle, tx_send pulse 1 cycle later with tx_data=8'hA5, grant_id=2, no further send until busy falls.
- Round robin: all four valid with bytes 8'h10,8'h11,8'h12,8'h13 held continuously -> tx_send sequence carries 10,11,12,13,10, each exactly once per frame.
- Busy pre-asserted: tx_busy=1 in IDLE and req_valid=4'b0001 -> req_ready stays 0 until tx_busy=0, then a grant occurs in the first cycle with tx_busy low.
- Withdrawn request: req 1 valid for 1 cycle during WAIT_LO then dropped, req 3 held -> req 3 is granted and req_ready[1] is never asserted.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, tx_busy tied 0: one request -> timeout_err pulses exactly 16 cycles after entering WAIT_HI, FSM returns to IDLE, and the next request is served.
